// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// -------------
// Multi-cycle integer execute unit. It accepts one operation per valid/ready
// handshake. Logic, add/sub and set-less-than complete in a single cycle.
// Shifts run through a bit-serial shifter that moves one bit per cycle.
// The result, zero flag and illegal-code flag are registered together.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   request valid
//   in_ready   unit can accept (IDLE only)
//   alu_ctrl   5-bit operation code
//   op_a       first operand / value to shift
//   op_b       second operand; the shift amount is op_b[SHW-1:0]
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   result     registered result
//   zero       result == 0
//   illegal    alu_ctrl was not a supported code
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b01010;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_SLT = 5'b01011;
    localparam logic [4:0] OP_SLL = 5'b00110;
    localparam logic [4:0] OP_SRL = 5'b00111;
    localparam logic [4:0] OP_SRA = 5'b00101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             illegal_reg, illegal_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [SHW-1:0]   count_reg, count_next;
    logic [4:0]       shop_reg, shop_next;

    // Single-cycle datapath, evaluated on the live inputs while IDLE.
    logic [WIDTH-1:0] alu_value;
    logic             alu_illegal;
    logic             is_shift;
    logic [SHW-1:0]   shamt;

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_value   = '0;
        alu_illegal = 1'b0;
        is_shift    = 1'b0;
        case (alu_ctrl)
            OP_AND: alu_value = op_a & op_b;
            OP_OR:  alu_value = op_a | op_b;
            OP_ADD: alu_value = op_a + op_b;
            OP_SUB: alu_value = op_a - op_b;
            OP_XOR: alu_value = op_a ^ op_b;
            OP_SLT: alu_value = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One-bit shift step of the serial shifter. Right shifts take their
    // incoming MSB from fill_bit so SRL and SRA share the same wiring.
    logic [WIDTH-1:0] shl_val, shr_val, shift_step;
    logic             fill_bit;

    assign fill_bit = (shop_reg == OP_SRA) ? shreg_reg[WIDTH-1] : 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl_val[gi] = 1'b0;
            end else begin : g_lsh
                assign shl_val[gi] = shreg_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign shr_val[gi] = fill_bit;
            end else begin : g_rsh
                assign shr_val[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    assign shift_step = (shop_reg == OP_SLL) ? shl_val : shr_val;

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        shreg_next   = shreg_reg;
        count_next   = count_reg;
        shop_next    = shop_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        shreg_next = op_a;
                        count_next = shamt;
                        shop_next  = alu_ctrl;
                        state_next = SHIFT;
                    end else begin
                        // A zero-distance shift simply returns op_a.
                        result_next  = is_shift ? op_a : alu_value;
                        zero_next    = is_shift ? (op_a == '0) : (alu_value == '0);
                        illegal_next = alu_illegal;
                        state_next   = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_next = shift_step;
                count_next = count_reg - SHW'(1);
                // The final step is written straight into the result so the
                // shift takes exactly shamt cycles in this state.
                if (count_reg == SHW'(1)) begin
                    result_next  = shift_step;
                    zero_next    = (shift_step == '0);
                    illegal_next = 1'b0;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            shreg_reg   <= '0;
            count_reg   <= '0;
            shop_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
            shreg_reg   <= shreg_next;
            count_reg   <= count_next;
            shop_reg    <= shop_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// ----------------
// Self-checking bench for alu_exec_unit (WIDTH=32). Directed cases cover the
// corner cases of each operation, latency, backpressure, back-to-back issue
// and reset during a shift; randomized operations follow. Expected values
// come from an arithmetic reference model of the operation codes.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: lat is the number of cycles spent shifting after the
    // accept edge (0 for single-cycle operations).
    function automatic void model(input logic [4:0] c, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic z, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        lat = 0;
        ill = 1'b0;
        case (c)
            5'b00000: r = a & b;
            5'b00001: r = a | b;
            5'b00010: r = a + b;
            5'b01010: r = a - b;
            5'b00100: r = a ^ b;
            5'b01011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'b00110: begin r = a << sh; lat = sh; end
            5'b00111: begin r = a >> sh; lat = sh; end
            5'b00101: begin r = 32'($signed(a) >>> sh); lat = sh; end
            default:  begin r = 32'd0; ill = 1'b1; end
        endcase
        z = (r == 32'd0);
    endfunction

    // Issue one operation, wait for its result, hold it for 'stall' cycles
    // with out_ready low, then accept it.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] er;
        logic ez, eil;
        int elat;
        int lat;
        model(c, a, b, er, ez, eil, elat);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        $display("txn ctrl=%b a=%h b=%h result=%h zero=%0b illegal=%0b lat=%0d",
                 c, a, b, result, zero, illegal, lat);
        check("latency", 32'(lat), 32'(elat));
        check("result", result, er);
        check("zero", 32'(zero), 32'(ez));
        check("illegal", 32'(illegal), 32'(eil));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_result", result, er);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_accept", 32'(in_ready), 32'd1);
        check("valid_after_accept", 32'(out_valid), 32'd0);
    endtask

    localparam logic [4:0] CODES [9] = '{5'b00000, 5'b00001, 5'b00010, 5'b01010,
                                          5'b00100, 5'b01011, 5'b00110, 5'b00111,
                                          5'b00101};

    initial begin
        logic [31:0] er;
        logic ez, eil;
        int elat;
        int seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        // Single-cycle operations
        run_op(5'b00010, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(5'b01010, 32'd5, 32'd7, 0);
        run_op(5'b01011, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(5'b01011, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(5'b00100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 0);
        run_op(5'b00000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1);

        // Shifts
        run_op(5'b00101, 32'h8000_0000, 32'd31, 0);
        run_op(5'b00111, 32'h8000_0000, 32'd31, 0);
        run_op(5'b00110, 32'h1, 32'hFFFF_FFE3, 0);
        run_op(5'b00110, 32'hDEAD_BEEF, 32'h20, 0);
        run_op(5'b00101, 32'h7000_0000, 32'd1, 0);

        // Illegal code, then a legal op clears the flag
        run_op(5'b11111, 32'h1234_5678, 32'h1, 0);
        run_op(5'b00010, 32'd3, 32'd4, 0);

        // Backpressure: result held, in_valid pulses ignored
        @(negedge clk);
        alu_ctrl = 5'b00001; op_a = 32'h00FF_0000; op_b = 32'h0000_00FF;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            alu_ctrl = 5'b00010; op_a = $urandom; op_b = $urandom;
            @(negedge clk);
            check("bp_result", result, 32'h00FF_00FF);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        $display("txn backpressure OR result=00ff00ff released");

        // Back-to-back non-shift ops, one result every two cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [4:0] c;
            c = CODES[$urandom_range(0, 5)];
            alu_ctrl = c; op_a = $urandom; op_b = $urandom;
            model(c, op_a, op_b, er, ez, eil, elat);
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            $display("txn b2b ctrl=%b a=%h b=%h result=%h", c, op_a, op_b, result);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_result", result, er);
            check("b2b_zero", 32'(zero), 32'(ez));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset during a shift discards the operation
        @(negedge clk);
        alu_ctrl = 5'b00110; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        check("rs_result", result, 32'd0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rs_no_stale_valid", 32'(seen), 32'd0);
        $display("txn reset during SLL shift, stale valid cycles=%0d", seen);

        // Randomized operations with random backpressure
        for (int k = 0; k < 24; k++) begin
            logic [4:0] c;
            if ($urandom_range(0, 7) == 0) c = 5'($urandom);
            else c = CODES[$urandom_range(0, 8)];
            run_op(c, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
